mux_n_stream: RTL and testbench
===============================

Name: mux_n_stream

Overview:
Parametrised N:1 streaming multiplexer, the successor to the fixed 4:1 combinational mux. It selects one of CH channels of WIDTH bits, using either a fixed select or round-robin arbitration. Each input channel and the output use a valid/ready handshake, and the output passes through a single registered stage. It sits between multiple producers and one shared consumer, for example a bus or FIFO write port.

Parameters:
WIDTH, 8, data bits per channel (>=1)
CH, 4, number of input channels (power of two, >=2)
SELW, $clog2(CH), select/channel-index width (derived localparam; not overridable)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
mode  in  1  0 = fixed select via sel; 1 = round-robin
sel  in  SELW  channel index used when mode=0
in_valid  in  CH  per-channel valid
in_data  in  CH*WIDTH  channel i occupies [i*WIDTH +: WIDTH]
in_ready  out  CH  per-channel ready (at most one bit high)
out_valid  out  1  output register holds a word
out_data  out  WIDTH  registered data
out_ch  out  SELW  index of the channel that supplied out_data
out_ready  in  1  consumer accepts the word

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high. While rst=1 at a clk edge: out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready is 0 during reset.
- Reset mid-operation: any held word is dropped and is not presented after reset.
- can_load = !out_valid | out_ready (the register is empty or draining this cycle).
- Grant (combinational, one-hot or zero):
  - mode=0: grant[sel] = in_valid[sel]; all other grant bits are 0. Other channels stall even when valid.
  - mode=1: the first i with in_valid[i]=1, searching ptr, ptr+1, ..., CH-1, 0, ..., ptr-1 (wrap-around).
- in_ready[i] = grant[i] & can_load & !rst. in_ready may depend combinationally on in_valid.
- Transfer on channel g: in_valid[g] & in_ready[g] at a clk edge. Next cycle: out_valid=1, out_data=in_data[g], out_ch=g.
- Latency: exactly 1 clk from input handshake to out_valid.
- Throughput: 1 word/clk. A simultaneous drain (out_valid & out_ready) and load in the same cycle reloads the register with no bubble.
- Drain without load: out_valid -> 0. out_data and out_ch keep their last value (don't-care for checking).
- Back-pressure: while out_valid & !out_ready, out_data and out_ch are held stable, in_ready = 0, and ptr is unchanged.
- Pointer:
  - Updated only on a transfer while mode=1: ptr <= (g+1) mod CH, so CH-1 wraps to 0.
  - Frozen while mode=0. Switching back to mode=1 resumes from the frozen ptr.
- Fairness: in mode=1 with all channels continuously valid, grants rotate 0,1,...,CH-1,0,... and no channel waits more than CH-1 transfers.
- mode/sel changes: sampled every cycle and affect only the next grant. A word already held is unaffected.
- No valid requester: no transfer, ptr unchanged.
- sel is always in range, because CH is a power of two.

Decomposition:
- Shared package mux_pkg: function onehot_to_idx (one-hot to index encoder).
- Sub-module rr_grant (parameter CH): inputs req[CH], ptr[SELW]; output grant[CH] (one-hot or zero). Implemented as a double-width masked priority search. Instantiated once.
- Data selection is an AND-OR of in_data slices with grant. No mux tree instances.

Test Plan:
1. Reset: assert rst 2 clks with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0 throughout.
2. Fixed select: mode=0, sel=2, in_valid=4'b1111, data ch0..3 = 8'h10,8'h21,8'h32,8'h43, out_ready=1 -> in_ready=4'b0100 every cycle; each output word = 8'h32 with out_ch=2, one word per clk after 1-clk latency.
3. Round-robin: mode=1, all four channels valid, out_ready=1, from reset -> out_ch sequence 0,1,2,3,0,1; in_ready one-hot rotating.
4. Sparse round-robin with wrap: ptr=3 (after a grant of ch2), in_valid=4'b0011 -> grant ch0, then ch1, then ch0. Channels 2 and 3 are never granted.
5. Back-pressure: out_valid=1 holding 8'h21 with out_ready=0 for 5 clks -> out_data=8'h21 stable, in_ready=0, ptr unchanged. Then out_ready=1 -> next word loaded same cycle with no bubble.
6. Mode switch and reset mid-operation:
   - mode=1 after grant ch1, switch to mode=0 with sel=3 for 3 transfers, then back to mode=1 with all valid -> first round-robin grant is ch2.
   - rst while out_valid=1 -> out_valid=0 next clk, and the held word is never seen.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared helpers for the streaming multiplexer: one-hot to index encoding.
package mux_pkg;

  localparam int MAX_CH   = 64;
  localparam int MAX_SELW = 6;

  // OR-reduction encoder; the input must be one-hot or zero.
  function automatic logic [MAX_SELW-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [MAX_SELW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | MAX_SELW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_n_stream_rr_grant.sv
// Round-robin grant: first requester at or after ptr, with wrap-around.
module rr_grant #(
  parameter int CH = 4
) (
  input  logic [CH-1:0]         req,
  input  logic [$clog2(CH)-1:0] ptr,
  output logic [CH-1:0]         grant
);

  logic [2*CH-1:0] dbl;
  logic [2*CH-1:0] rot;
  logic [CH-1:0]   low;
  logic [CH-1:0]   pick;
  logic [2*CH-1:0] back;

  // Rotate requests so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl   = {req, req};
    rot   = dbl >> ptr;
    low   = rot[CH-1:0];
    pick  = low & (~low + CH'(1));
    back  = {pick, pick} << ptr;
    grant = back[2*CH-1:CH];
  end

endmodule

// File: rtl/mux_n_stream.sv
// N:1 streaming multiplexer with fixed or round-robin selection and one output register.
module mux_n_stream
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CH    = 4,
  localparam int SELW  = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [CH-1:0]         in_valid,
  input  logic [CH*WIDTH-1:0]   in_data,
  output logic [CH-1:0]         in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic [CH-1:0]    grant_rr;
  logic [CH-1:0]    grant_fixed;
  logic [CH-1:0]    grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             can_load;
  logic             xfer;

  rr_grant #(.CH(CH)) u_rr_grant (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (grant_rr)
  );

  always_comb begin
    grant_fixed      = '0;
    grant_fixed[sel] = in_valid[sel];
    grant            = mode ? grant_rr : grant_fixed;
    can_load         = !out_valid_q || out_ready;
    in_ready         = grant & {CH{can_load && !rst}};
    xfer             = |in_ready;
    grant_idx        = SELW'(onehot_to_idx(MAX_CH'(grant)));
  end

  // Grant is one-hot or zero, so an AND-OR picks the winning slice.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CH; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (can_load) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_data_d = sel_data;
      out_ch_d   = grant_idx;
      if (mode) ptr_d = grant_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_stream.sv
// Randomized and directed bench for mux_n_stream against a cycle-level reference model.
module tb_mux_n_stream;

  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int SELW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [CH-1:0]       in_valid;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_ready;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_ch;
  logic                out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_valid;
  bit m_zero;
  int m_data;
  int m_ch;
  int m_ptr;
  int obs_ch[$];

  always #5 clk = ~clk;

  mux_n_stream #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    int c;
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < CH; k++) begin
      c = (m_ptr + k) % CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check at the falling edge, advance the model across the rising edge.
  task automatic step();
    int  g;
    bit  can_load;
    int  exp_rdy;
    bit  n_valid, n_zero;
    int  n_data, n_ch, n_ptr;
    @(negedge clk);
    g        = exp_grant();
    can_load = !m_valid || out_ready;
    exp_rdy  = (g >= 0 && can_load && !rst) ? (1 << g) : 0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || m_zero) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
    end
    if (out_valid) obs_ch.push_back(int'(out_ch));
    n_valid = m_valid; n_zero = m_zero; n_data = m_data; n_ch = m_ch; n_ptr = m_ptr;
    if (rst) begin
      n_valid = 0; n_zero = 1; n_data = 0; n_ch = 0; n_ptr = 0;
    end else if (can_load) begin
      if (g >= 0) begin
        n_valid = 1;
        n_zero  = 0;
        n_data  = int'(in_data[g*WIDTH +: WIDTH]);
        n_ch    = g;
        if (mode) n_ptr = (g + 1) % CH;
      end else begin
        if (m_valid) n_zero = 0;
        n_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_zero = n_zero; m_data = n_data; m_ch = n_ch; m_ptr = n_ptr;
  endtask

  task automatic drive(input bit r, input bit md, input int s, input logic [CH-1:0] v, input bit ordy);
    rst = r; mode = md; sel = SELW'(s); in_valid = v; out_ready = ordy;
  endtask

  task automatic set_fixed_data();
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
  endtask

  task automatic check_seq(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, 32'(obs_ch.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_ch.size(); i++)
      chk(tag, 32'(obs_ch[i]), 32'(exp_q[i]));
  endtask

  initial begin
    m_valid = 0; m_zero = 0; m_data = 0; m_ch = 0; m_ptr = 0;
    set_fixed_data();
    drive(1, 0, 0, 4'b1111, 1);
    @(posedge clk); #1;
    m_zero = 1;

    // Reset held two cycles with every channel requesting
    repeat (2) step();

    // Fixed select of channel 2
    drive(0, 0, 2, 4'b1111, 1);
    repeat (5) step();

    // Round-robin from reset with all channels valid
    drive(1, 1, 0, 4'b1111, 1);
    step();
    drive(0, 1, 0, 4'b1111, 1);
    obs_ch.delete();
    repeat (7) step();
    check_seq("rr_seq", '{0, 1, 2, 3, 0, 1});

    // Sparse round-robin with wrap after a grant of channel 2
    drive(1, 1, 0, 4'b0000, 1);
    step();
    obs_ch.delete();
    drive(0, 1, 0, 4'b0100, 1);
    step();
    drive(0, 1, 0, 4'b0011, 1);
    repeat (3) step();
    drive(0, 1, 0, 4'b0000, 1);
    step();
    check_seq("rr_wrap", '{2, 0, 1, 0});

    // Back-pressure holding channel 1's word, then drain and reload together
    drive(1, 0, 0, 4'b0000, 1);
    step();
    drive(0, 0, 1, 4'b0010, 1);
    step();
    drive(0, 1, 0, 4'b1111, 0);
    repeat (5) step();
    drive(0, 1, 0, 4'b1111, 1);
    repeat (3) step();

    // Mode switch: grant ch1, three fixed transfers of ch3, resume round-robin at ch2
    drive(1, 1, 0, 4'b0000, 1);
    step();
    obs_ch.delete();
    drive(0, 1, 0, 4'b0010, 1);
    step();
    drive(0, 0, 3, 4'b1111, 1);
    repeat (3) step();
    drive(0, 1, 0, 4'b1111, 1);
    repeat (2) step();
    check_seq("mode_sw", '{1, 3, 3, 3, 2});

    // Reset while a word is held under back-pressure
    drive(0, 1, 0, 4'b1111, 0);
    step();
    drive(1, 1, 0, 4'b1111, 0);
    step();
    drive(0, 1, 0, 4'b0000, 1);
    repeat (2) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SELW'($urandom_range(0, CH - 1));
      in_valid  = CH'($urandom);
      in_data   = (CH*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
